// File: rtl/piso_tx_sched.sv
// Two-requester round-robin scheduler feeding one MSB-first parallel-in/serial-out shifter.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_tx_sched #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             sout_id,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifndef PISO_PARITY_EN
  localparam logic [CW-1:0] LAST_M1 = CW'(WIDTH - 2);
`endif

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef PISO_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             prio;
  logic             gnt0;
  logic             gnt1;
  logic             accept;
  logic [WIDTH-1:0] win_data;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  // Handshake: a word transfers on a rising edge where valid && ready; ready is
  // only offered in IDLE, to one requester, and never while rst is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && !rst) begin
      gnt0 = req0_valid && (!req1_valid || !prio);
      gnt1 = req1_valid && (!req0_valid || prio);
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign accept     = gnt0 | gnt1;
  assign win_data   = gnt1 ? req1_data : req0_data;
  assign busy       = (state != IDLE);
  assign state_dbg  = state;
  // The shifter MSB is the serial output flop; clearing shreg idles the line at 0.
  assign sout       = shreg[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      prio       <= 1'b0;
      sout_valid <= 1'b0;
      sout_last  <= 1'b0;
      sout_id    <= 1'b0;
`ifdef PISO_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg      <= win_data;
            cnt        <= '0;
            sout_valid <= 1'b1;
            sout_last  <= 1'b0;
            sout_id    <= gnt1;
            prio       <= ~gnt1;
            state      <= SHIFT;
`ifdef PISO_PARITY_EN
            par        <= ^win_data;
`endif
          end
        end
        SHIFT: begin
          if (cnt == LAST) begin
`ifdef PISO_PARITY_EN
            shreg      <= {par, {(WIDTH-1){1'b0}}};
            sout_last  <= 1'b1;
            state      <= PARITY;
`else
            shreg      <= '0;
            sout_valid <= 1'b0;
            sout_last  <= 1'b0;
            state      <= IDLE;
`endif
          end else begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            cnt   <= cnt + 1'b1;
`ifdef PISO_PARITY_EN
            sout_last <= 1'b0;
`else
            sout_last <= (cnt == LAST_M1);
`endif
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          shreg      <= '0;
          sout_valid <= 1'b0;
          sout_last  <= 1'b0;
          state      <= IDLE;
        end
`endif
        default: begin
          shreg      <= '0;
          sout_valid <= 1'b0;
          sout_last  <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
